// File: rtl/cpu_phase_sequencer.sv
// One-hot phase sequencer for the nonpipelined datapath: walks the stage enables,
// stalls the memory phase on mem_busy, counts retired instructions and stall cycles.
module cpu_phase_sequencer #(
  parameter int NUM_PHASES = 5,
  parameter int MEM_PHASE  = 3,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  run,
  input  logic [CNT_W-1:0]      instr_limit,
  input  logic                  halt_req,
  input  logic                  mem_busy,
  output logic [NUM_PHASES-1:0] phase_en,
  output logic                  running,
  output logic                  done,
  output logic [CNT_W-1:0]      instr_count,
  output logic [CNT_W-1:0]      stall_count
);

  localparam int PTR_W = $clog2(NUM_PHASES);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_STALL = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [PTR_W-1:0]      LAST_PTR = PTR_W'(NUM_PHASES - 1);
  localparam logic [PTR_W-1:0]      MEM_PTR  = PTR_W'(MEM_PHASE);
  localparam logic [PTR_W-1:0]      PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0]      CNT_ONE  = CNT_W'(1);
  localparam logic [NUM_PHASES-1:0] PH_ONE   = NUM_PHASES'(1);

  logic [1:0]            state_q, state_d;
  logic [PTR_W-1:0]      ptr_q, ptr_d;
  logic                  halt_q, halt_d;
  logic [CNT_W-1:0]      icnt_q, icnt_d;
  logic [CNT_W-1:0]      scnt_q, scnt_d;
  logic [NUM_PHASES-1:0] phase_en_q, phase_en_d;
  logic                  running_q, running_d;
  logic                  done_q, done_d;
  logic                  stall_s;
  logic                  limit_hit_s;
  logic                  active_d_s;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : (v + CNT_ONE);
  endfunction

  // Next-state, phase pointer and counter update
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    halt_d      = halt_q;
    icnt_d      = icnt_q;
    scnt_d      = scnt_q;
    stall_s     = (ptr_q == MEM_PTR) && mem_busy;
    // instr_limit is live: compared against the count this retire would produce
    limit_hit_s = (instr_limit != '0) && ((icnt_q + CNT_ONE) == instr_limit);
    case (state_q)
      S_IDLE: begin
        if (run) begin
          state_d = S_RUN;
          ptr_d   = '0;
          halt_d  = 1'b0;
          icnt_d  = '0;
          scnt_d  = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN, S_STALL: begin
        halt_d = halt_q | halt_req;
        if (stall_s) begin
          state_d = S_STALL;
          scnt_d  = sat_inc(scnt_q);
        end else if (ptr_q == LAST_PTR) begin
          icnt_d = sat_inc(icnt_q);
          ptr_d  = '0;
          if (halt_q || halt_req || limit_hit_s) begin
            state_d = S_DONE;
          end else begin
            state_d = S_RUN;
          end
        end else begin
          state_d = S_RUN;
          ptr_d   = ptr_q + PTR_ONE;
        end
      end
      S_DONE: begin
        if (!run) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
        ptr_d   = '0;
      end
    endcase
  end

  // Registered output decode from the next state keeps outputs glitch-free
  always_comb begin
    active_d_s = (state_d == S_RUN) || (state_d == S_STALL);
    running_d  = active_d_s;
    done_d     = (state_d == S_DONE);
    if (active_d_s) begin
      phase_en_d = PH_ONE << ptr_d;
    end else begin
      phase_en_d = '0;
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      halt_q     <= 1'b0;
      icnt_q     <= '0;
      scnt_q     <= '0;
      phase_en_q <= '0;
      running_q  <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      halt_q     <= halt_d;
      icnt_q     <= icnt_d;
      scnt_q     <= scnt_d;
      phase_en_q <= phase_en_d;
      running_q  <= running_d;
      done_q     <= done_d;
    end
  end

  assign phase_en    = phase_en_q;
  assign running     = running_q;
  assign done        = done_q;
  assign instr_count = icnt_q;
  assign stall_count = scnt_q;

endmodule

// File: tb/tb_cpu_phase_sequencer.sv
// Directed bench for cpu_phase_sequencer: a vector table for the basic run,
// plus hand-written sequences for stall, halt, async reset and saturation.
module tb_cpu_phase_sequencer;

  logic        clk;
  logic        reset;
  logic        run;
  logic [31:0] instr_limit;
  logic        halt_req;
  logic        mem_busy;
  logic [4:0]  phase_en;
  logic        running;
  logic        done;
  logic [31:0] instr_count;
  logic [31:0] stall_count;

  logic        run3;
  logic [3:0]  limit3;
  logic        halt3;
  logic        busy3;
  logic [2:0]  phase3;
  logic        running3;
  logic        done3;
  logic [3:0]  icnt3;
  logic [3:0]  scnt3;

  int tests;
  int fails;

  cpu_phase_sequencer dut (
    .clk(clk), .reset(reset), .run(run), .instr_limit(instr_limit),
    .halt_req(halt_req), .mem_busy(mem_busy), .phase_en(phase_en),
    .running(running), .done(done), .instr_count(instr_count),
    .stall_count(stall_count)
  );

  cpu_phase_sequencer #(.NUM_PHASES(3), .MEM_PHASE(0), .CNT_W(4)) dut3 (
    .clk(clk), .reset(reset), .run(run3), .instr_limit(limit3),
    .halt_req(halt3), .mem_busy(busy3), .phase_en(phase3),
    .running(running3), .done(done3), .instr_count(icnt3),
    .stall_count(scnt3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        run;
    logic        halt;
    logic        busy;
    logic [31:0] limit;
    logic [4:0]  phase;
    logic        running;
    logic        done;
    logic [31:0] icnt;
    logic [31:0] scnt;
  } vec_t;

  vec_t tv[20];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_main(input string tag, input logic [4:0] ph, input logic r,
                          input logic d, input logic [31:0] ic, input logic [31:0] sc);
    chk({tag, ".phase"}, 64'(phase_en), 64'(ph));
    chk({tag, ".running"}, 64'(running), 64'(r));
    chk({tag, ".done"}, 64'(done), 64'(d));
    chk({tag, ".icnt"}, 64'(instr_count), 64'(ic));
    chk({tag, ".scnt"}, 64'(stall_count), 64'(sc));
  endtask

  task automatic do_reset();
    reset = 1'b0;
    run = 1'b0; halt_req = 1'b0; mem_busy = 1'b0; instr_limit = 32'd0;
    step();
    reset = 1'b1;
  endtask

  initial begin
    tests = 0; fails = 0;
    run3 = 1'b0; limit3 = 4'd0; halt3 = 1'b0; busy3 = 1'b0;

    // Table: limit=3 run, DONE hold with run=1, return to IDLE, restart
    for (int i = 0; i < 15; i++) begin
      tv[i] = '{run: 1'b1, halt: 1'b0, busy: 1'b0, limit: 32'd3,
                phase: 5'(5'b00001 << (i % 5)), running: 1'b1, done: 1'b0,
                icnt: 32'(i / 5), scnt: 32'd0};
    end
    tv[15] = '{1'b1, 1'b0, 1'b0, 32'd3, 5'b00000, 1'b0, 1'b1, 32'd3, 32'd0};
    tv[16] = '{1'b1, 1'b0, 1'b0, 32'd3, 5'b00000, 1'b0, 1'b1, 32'd3, 32'd0};
    tv[17] = '{1'b0, 1'b0, 1'b0, 32'd3, 5'b00000, 1'b0, 1'b0, 32'd3, 32'd0};
    tv[18] = '{1'b1, 1'b0, 1'b0, 32'd3, 5'b00001, 1'b1, 1'b0, 32'd0, 32'd0};
    tv[19] = '{1'b0, 1'b0, 1'b0, 32'd3, 5'b00010, 1'b1, 1'b0, 32'd0, 32'd0};

    do_reset();
    chk_main("reset", 5'b00000, 1'b0, 1'b0, 32'd0, 32'd0);
    step();
    chk_main("idle", 5'b00000, 1'b0, 1'b0, 32'd0, 32'd0);

    for (int i = 0; i < 20; i++) begin
      run = tv[i].run; halt_req = tv[i].halt; mem_busy = tv[i].busy;
      instr_limit = tv[i].limit;
      step();
      chk_main($sformatf("vec%0d", i), tv[i].phase, tv[i].running, tv[i].done,
               tv[i].icnt, tv[i].scnt);
    end

    // Stall in memory phase, limit=1; busy outside memory phase is ignored
    do_reset();
    run = 1'b1; instr_limit = 32'd1;
    step();
    chk_main("st.p0", 5'b00001, 1'b1, 1'b0, 32'd0, 32'd0);
    mem_busy = 1'b1;
    step();
    chk_main("st.p1", 5'b00010, 1'b1, 1'b0, 32'd0, 32'd0);
    mem_busy = 1'b0;
    step();
    step();
    chk_main("st.p3", 5'b01000, 1'b1, 1'b0, 32'd0, 32'd0);
    mem_busy = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step();
      chk_main($sformatf("st.hold%0d", i), 5'b01000, 1'b1, 1'b0, 32'd0, 32'(i));
    end
    mem_busy = 1'b0;
    step();
    chk_main("st.p4", 5'b10000, 1'b1, 1'b0, 32'd0, 32'd4);
    step();
    chk_main("st.done", 5'b00000, 1'b0, 1'b1, 32'd1, 32'd4);

    // Halt pulse during phase 1 of instruction 2, unlimited
    do_reset();
    run = 1'b1; instr_limit = 32'd0;
    for (int i = 0; i < 7; i++) step();
    chk_main("h.i2p1", 5'b00010, 1'b1, 1'b0, 32'd1, 32'd0);
    halt_req = 1'b1;
    step();
    halt_req = 1'b0;
    chk_main("h.i2p2", 5'b00100, 1'b1, 1'b0, 32'd1, 32'd0);
    step();
    step();
    chk_main("h.i2p4", 5'b10000, 1'b1, 1'b0, 32'd1, 32'd0);
    step();
    chk_main("h.done", 5'b00000, 1'b0, 1'b1, 32'd2, 32'd0);
    step();
    chk_main("h.hold", 5'b00000, 1'b0, 1'b1, 32'd2, 32'd0);

    // Async reset mid-STALL, then a fresh start
    do_reset();
    run = 1'b1; instr_limit = 32'd0;
    for (int i = 0; i < 4; i++) step();
    mem_busy = 1'b1;
    step();
    step();
    chk_main("ar.stall", 5'b01000, 1'b1, 1'b0, 32'd0, 32'd2);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk_main("ar.async", 5'b00000, 1'b0, 1'b0, 32'd0, 32'd0);
    #2;
    reset = 1'b1;
    mem_busy = 1'b0;
    step();
    chk_main("ar.restart", 5'b00001, 1'b1, 1'b0, 32'd0, 32'd0);
    run = 1'b0;

    // Three-phase instance: wrap and saturation of a 4-bit count
    do_reset();
    run3 = 1'b1;
    step();
    chk("p3.e1", 64'(phase3), 64'(3'b001));
    step();
    chk("p3.e2", 64'(phase3), 64'(3'b010));
    step();
    chk("p3.e3", 64'(phase3), 64'(3'b100));
    step();
    chk("p3.e4", 64'(phase3), 64'(3'b001));
    chk("p3.icnt1", 64'(icnt3), 64'(4'd1));
    for (int i = 5; i <= 45; i++) step();
    chk("p3.icnt14", 64'(icnt3), 64'(4'd14));
    step();
    chk("p3.icnt15", 64'(icnt3), 64'(4'd15));
    for (int i = 47; i <= 61; i++) step();
    chk("p3.sat", 64'(icnt3), 64'(4'd15));
    chk("p3.running", 64'(running3), 64'(1'b1));
    chk("p3.phase", 64'(phase3), 64'(3'b001));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cpu_phase_sequencer.md
Name: cpu_phase_sequencer

Overview:
- Single-clock, parametrised replacement for the free-running oscillator, the fixed delay taps and the testbench-timed run/finish control of the nonpipelined datapath.
- Drives one-hot phase enables for the stages: fetch, decode-read, execute, memory, writeback.
- Stalls the memory phase on a busy handshake and counts retired instructions and stall cycles.
- Stops cleanly on a halt request or an instruction limit.

Parameters:
- NUM_PHASES, 5, number of phases per instruction (>=2).
- MEM_PHASE, 3, index of the phase that may be stalled by mem_busy (0..NUM_PHASES-1).
- CNT_W, 32, width of the limit and counter ports.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset (asserted at 0).
- run  input  1  level start request, sampled in IDLE.
- instr_limit  input  CNT_W  instructions to retire before stopping; 0 = unlimited.
- halt_req  input  1  single-cycle or level halt request, e.g. from a decoded HALT.
- mem_busy  input  1  memory not ready; honoured only while phase MEM_PHASE is active.
- phase_en  output  NUM_PHASES  one-hot phase enable, registered.
- running  output  1  high in RUN and STALL.
- done  output  1  high in DONE.
- instr_count  output  CNT_W  instructions retired since the last start.
- stall_count  output  CNT_W  stall cycles since the last start.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; phase_en=0; running=0; done=0.
  - instr_count=0; stall_count=0; halt_pending=0; phase pointer=0.
  - Reset asserted mid-instruction aborts at once with no partial count.
- States: IDLE, RUN, STALL, DONE. Encoding is free.
- IDLE:
  - run=1 at edge k: next state RUN; phase_en=1 (bit 0) from edge k.
  - Same edge: instr_count=0, stall_count=0, halt_pending=0.
- RUN:
  - Each edge rotates phase_en left by one; bit NUM_PHASES-1 wraps to bit 0.
  - One phase per cycle: an unstalled instruction takes exactly NUM_PHASES cycles.
- Stall:
  - At an edge where phase_en[MEM_PHASE]=1 and mem_busy=1: phase_en holds, state becomes STALL, stall_count increments.
  - STALL repeats the same check each cycle.
  - Edge with mem_busy=0: phase_en advances and state returns to RUN.
  - mem_busy in any other phase is ignored.
- Retire: an edge leaving phase NUM_PHASES-1 increments instr_count. instr_count saturates at all-ones; stall_count saturates likewise.
- Halt:
  - halt_req=1 at any edge in RUN or STALL sets sticky halt_pending. It does not truncate the current instruction.
  - At the retire edge, go to DONE if halt_pending=1, or halt_req=1 on that edge, or (instr_limit!=0 and instr_count+1==instr_limit).
  - Otherwise wrap to phase 0.
- DONE:
  - phase_en=0; done=1; running=0; counters frozen.
  - run=0 returns the block to IDLE. run held at 1 stays in DONE (no auto-restart).
- Other input rules:
  - run deasserted during RUN or STALL is ignored.
  - instr_limit is sampled live at each retire edge.
- Simultaneous events:
  - halt_req with mem_busy in MEM_PHASE: the stall proceeds and the halt is latched.
  - instr_limit=1: the first instruction retires, then DONE.
- Outputs are glitch-free registers; no combinational path from inputs to phase_en.

Test Plan:
- Defaults; reset=0 then 1; run=1 at cycle 2, limit=3, mem_busy=0.
  - Required: phase_en sequence 00001,00010,00100,01000,10000, repeated three times.
  - Required: DONE at cycle 17, instr_count=3, stall_count=0, done=1, phase_en=0.
- mem_busy=1 for 4 cycles while phase_en=01000, limit=1.
  - Required: phase_en holds 01000 for 5 cycles total.
  - Required: stall_count=4, instr_count=1, 9 cycles from start to DONE.
- Limit=0; pulse halt_req for one cycle during phase 1 of instruction 2.
  - Required: instruction 2 completes all 5 phases, instr_count=2, then DONE.
  - Required: no phase-0 pulse after retire.
- Assert reset=0 mid-STALL with stall_count=2.
  - Required: immediately phase_en=0, stall_count=0, state IDLE without waiting for a clock edge.
  - Required: after release with run=1, a fresh start from phase 0.
- In DONE with run held 1: stays DONE.
  - Required: run=0 for one cycle, then run=1 → restart with counters cleared.
- NUM_PHASES=3, MEM_PHASE=0, CNT_W=4, limit=0, run=1 for 20 instructions.
  - Required: phase_en wraps 001→010→100→001.
  - Required: instr_count saturates at 15.
